muldiv_unit: RTL and testbench

- Iterative integer multiply/divide unit implementing the RV64M extension (RV32M when XLEN=32).
- Sits beside the combinational ALU in the execute stage and is parametrised in datapath width.
- Uses a valid/ready handshake on both the request and response sides, with one operation in flight at a time.
- Supports a flush input so that wrong-path operations can be cancelled.

---
 rtl/muldiv_unit.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV64M/RV32M multiply/divide unit with valid/ready handshakes and flush.
// Define MULDIV_FAST_MUL_EN to use a single-cycle combinational multiplier.
module muldiv_unit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic             word_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam logic [2:0] OpMul = 3'd0, OpMulh = 3'd1, OpMulhsu = 3'd2, OpMulhu = 3'd3;
  localparam logic [2:0] OpDiv = 3'd4, OpDivu = 3'd5, OpRem = 3'd6, OpRemu = 3'd7;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, opb_q, opb_d;
  logic [XLEN-1:0]   opa_q, opa_d, result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  logic              word_eff, accept;
  logic [2:0]        op_eff;
  logic              signed_a, signed_b, sign_a, sign_b, div_zero, div_ovf;
  logic [XLEN-1:0]   ext_a, ext_b, abs_a, abs_b, spec_res;
  logic [XLEN:0]     rem_sh, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return XLEN'($signed(v[31:0]));
  endfunction

  assign word_eff = (XLEN == 64) && word_i;
  // Word forms of MULH* do not exist; they collapse onto MULW.
  assign op_eff   = (word_eff && !op_i[2]) ? OpMul : op_i;
  assign accept   = valid_i && (state_q == StIdle) && !flush_i;

  always_comb begin
    ext_a = op_a_i;
    ext_b = op_b_i;
    if (word_eff) begin
      if (op_eff == OpDivu || op_eff == OpRemu) begin
        ext_a = XLEN'(op_a_i[31:0]);
        ext_b = XLEN'(op_b_i[31:0]);
      end else begin
        ext_a = sext32(op_a_i);
        ext_b = sext32(op_b_i);
      end
    end
    signed_a = op_eff inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    signed_b = op_eff inside {OpMulh, OpDiv, OpRem};
    sign_a   = signed_a && ext_a[XLEN-1];
    sign_b   = signed_b && ext_b[XLEN-1];
    abs_a    = sign_a ? -ext_a : ext_a;
    abs_b    = sign_b ? -ext_b : ext_b;
    div_zero = op_eff[2] && (ext_b == '0);
    if (word_eff) begin
      div_ovf = (op_eff == OpDiv || op_eff == OpRem) && (ext_a[31:0] == 32'h8000_0000)
                && (ext_b[31:0] == 32'hffff_ffff);
    end else begin
      div_ovf = (op_eff == OpDiv || op_eff == OpRem) && (ext_a == {1'b1, {(XLEN-1){1'b0}}})
                && (ext_b == '1);
    end
    // op[1] selects the remainder among divide ops.
    if (op_eff[1]) spec_res = div_zero ? ext_a : '0;
    else           spec_res = div_zero ? '1 : ext_a;
    if (word_eff) spec_res = sext32(spec_res);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    op_d      = op_q;
    word_d    = word_q;
    tag_d     = tag_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    rem_sh = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
    diff   = rem_sh - {1'b0, opb_q[XLEN-1:0]};
    prod   = neg_res_q ? -acc_q : acc_q;
    quo    = neg_res_q ? -opa_q : opa_q;
    rem    = neg_rem_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    case (op_q)
      OpMul:                     fix_res = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_res = prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fix_res = quo;
      default:                   fix_res = rem;
    endcase
    if (word_q) fix_res = sext32(fix_res);

    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d      = op_eff;
          word_d    = word_eff;
          tag_d     = tag_i;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          cnt_d     = word_eff ? CntW'(32) : CntW'(XLEN);
          acc_d     = '0;
          opa_d     = abs_a;
          opb_d     = {{XLEN{1'b0}}, abs_b};
          if (div_zero || div_ovf) begin
            result_d = spec_res;
            state_d  = StDone;
          end else if (op_eff[2]) begin
            // Align a 32-bit dividend to the top so 32 steps consume it fully.
            if (word_eff) opa_d = abs_a << (XLEN - 32);
            state_d = StCalc;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            acc_d   = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
            state_d = StFix;
`else
            state_d = StCalc;
`endif
          end
        end
      end
      StCalc: begin
        if (op_q[2]) begin
          acc_d = {{XLEN{1'b0}}, (diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0])};
          opa_d = {opa_q[XLEN-2:0], ~diff[XLEN]};
        end else begin
          acc_d = opa_q[0] ? acc_q + opb_q : acc_q;
          opa_d = opa_q >> 1;
          opb_d = opb_q << 1;
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        result_d = fix_res;
        state_d  = StDone;
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      word_q    <= 1'b0;
      tag_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      op_q      <= op_d;
      word_q    <= word_d;
      tag_q     <= tag_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign valid_o  = (state_q == StDone);
  assign busy_o   = (state_q != StIdle);
  assign result_o = result_q;
  assign tag_o    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=64) using immediate assertions.
module tb_muldiv_unit;

  logic        clk_i, rst_ni, valid_i, ready_o, word_i, flush_i, valid_o, ready_i, busy_o;
  logic [2:0]  op_i;
  logic [63:0] op_a_i, op_b_i, result_o;
  logic [4:0]  tag_i, tag_o;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat  = 2;
  localparam int MulLatW = 2;
`else
  localparam int MulLat  = 66;
  localparam int MulLatW = 34;
`endif

  muldiv_unit #(.XLEN(64), .TAG_W(5)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .word_i  (word_i),
    .op_a_i  (op_a_i),
    .op_b_i  (op_b_i),
    .tag_i   (tag_i),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .result_o(result_o),
    .tag_o   (tag_o),
    .busy_o  (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Issue one request from IDLE, measure latency, check result/tag, then complete handshake.
  task automatic run_op(input string name, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] tg,
                        input logic [63:0] exp_r, input int exp_lat);
    int lat;
    op_i = op; word_i = w; op_a_i = a; op_b_i = b; tag_i = tg; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    op_a_i  = ~a;
    op_b_i  = ~b;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " result"}, result_o, exp_r);
    chk({name, " tag"}, 64'(tag_o), 64'(tg));
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    chk({name, " idle after handshake"}, {62'd0, valid_o, ready_o}, 64'd1);
  endtask

  initial begin
    int  hold_bad;
    logic saw_valid;
    rst_ni = 1'b0; valid_i = 1'b0; op_i = '0; word_i = 1'b0; op_a_i = '0; op_b_i = '0;
    tag_i = '0; flush_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset outputs", {result_o, 59'd0, tag_o} , 64'd0);
    chk("reset flags", {61'd0, valid_o, ready_o, busy_o}, 64'b010);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run_op("MUL -1*3", 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd1,
           64'hFFFF_FFFF_FFFF_FFFD, MulLat);
    run_op("MULHU", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2,
           64'hFFFF_FFFF_FFFF_FFFE, MulLat);
    run_op("MULHSU", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3,
           64'hFFFF_FFFF_FFFF_FFFF, MulLat);
    run_op("MULH", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4,
           64'd0, MulLat);
    run_op("DIV -7/2", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5,
           64'hFFFF_FFFF_FFFF_FFFD, 66);
    run_op("REM -7%2", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6,
           64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_op("DIVU by 0", 3'd5, 1'b0, 64'd7, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("REMU by 0", 3'd7, 1'b0, 64'd7, 64'd0, 5'd8, 64'd7, 1);
    run_op("DIV ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9,
           64'h8000_0000_0000_0000, 1);
    run_op("REM ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10,
           64'd0, 1);
    run_op("DIVW ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd11,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("MULW", 3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd12,
           64'hFFFF_FFFF_FFFF_FFFE, MulLatW);
    run_op("MULHW as MULW", 3'd1, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd13,
           64'hFFFF_FFFF_FFFF_FFFE, MulLatW);
    run_op("DIVUW", 3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 5'd14,
           64'h0000_0000_7FFF_FFFF, 34);
    run_op("REMW -7%2", 3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd15,
           64'hFFFF_FFFF_FFFF_FFFF, 34);

    // Hold result with ready_i low for several cycles.
    op_i = 3'd4; word_i = 1'b0; op_a_i = 64'd100; op_b_i = 64'd7; tag_i = 5'd21;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    for (int i = 0; i < 200 && !valid_o; i++) begin
      @(posedge clk_i); #1;
    end
    hold_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (result_o !== 64'd14 || tag_o !== 5'd21 || valid_o !== 1'b1 || ready_o !== 1'b0)
        hold_bad++;
      @(posedge clk_i); #1;
    end
    chk("hold stable 5 cycles", 64'(hold_bad), 64'd0);
    chk("hold result", result_o, 64'd14);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    chk("hold released", {61'd0, valid_o, ready_o, busy_o}, 64'b010);

    // Flush mid-CALC.
    op_i = 3'd0; op_a_i = 64'd5; op_b_i = 64'd6; tag_i = 5'd22; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    chk("busy before flush", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush returns idle", {61'd0, valid_o, ready_o, busy_o}, 64'b010);
    saw_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (valid_o) saw_valid = 1'b1;
      @(posedge clk_i); #1;
    end
    chk("no valid after flush", 64'(saw_valid), 64'd0);

    // Request presented together with flush is dropped.
    op_i = 3'd5; op_a_i = 64'd7; op_b_i = 64'd0; valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    chk("request dropped by flush", {61'd0, valid_o, ready_o, busy_o}, 64'b010);

    // Asynchronous reset mid-CALC.
    op_i = 3'd4; op_a_i = 64'd1000; op_b_i = 64'd3; tag_i = 5'd30; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async reset flags", {61'd0, valid_o, ready_o, busy_o}, 64'b010);
    chk("async reset result", result_o, 64'd0);
    chk("async reset tag", 64'(tag_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run_op("DIVU after reset", 3'd5, 1'b0, 64'd1000, 64'd3, 5'd31, 64'd333, 66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
